// File: rtl/bcd_xs3_seq_converter.sv
// ---------------------------------------------------------------------------
// bcd_xs3_seq_converter
//
// Sequential multi-digit BCD <-> Excess-3 converter. It accepts one word of
// DIGITS packed 4-bit digits over a valid/ready handshake. The word is then
// converted one digit per clock, least-significant digit first. The result
// is presented over a second valid/ready handshake.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   in_data / in_mode are valid
//   in_ready   block can accept a word (high only while idle)
//   in_data    packed digits, digit i = in_data[4i+3:4i]
//   in_mode    0 = BCD -> XS3, 1 = XS3 -> BCD
//   out_valid  out_data / out_err are valid
//   out_ready  downstream accepts the result
//   out_data   converted digits, same packing as in_data
//   out_err    bit i set = digit i was out of range (its data forced to 4'hF)
//   busy       converter is not idle
// ---------------------------------------------------------------------------
module bcd_xs3_seq_converter #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_data,
    input  logic                  in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_data,
    output logic [DIGITS-1:0]     out_err,
    output logic                  busy
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Converts one digit. The return value is {err, result}. An out-of-range
    // digit yields result 4'hF with err set.
    function automatic logic [4:0] conv_digit(input logic [3:0] d, input logic mode);
        logic [4:0] r;
        if (mode == 1'b0) begin
            if (d <= 4'd9) begin
                r = {1'b0, d + 4'd3};
            end else begin
                r = {1'b1, 4'hF};
            end
        end else begin
            if ((d >= 4'd3) && (d <= 4'd12)) begin
                r = {1'b0, d - 4'd3};
            end else begin
                r = {1'b1, 4'hF};
            end
        end
        return r;
    endfunction

    logic [1:0]            state_r;
    logic [1:0]            state_nxt_s;
    logic [IDX_W-1:0]      idx_r;
    logic [4*DIGITS-1:0]   data_r;
    logic                  mode_r;
    logic [4*DIGITS-1:0]   out_data_r;
    logic [DIGITS-1:0]     out_err_r;
    logic                  out_valid_r;
    logic                  busy_r;
    logic [3:0]            cur_digit_s;
    logic [4:0]            conv_s;

    assign in_ready  = (state_r == IDLE);
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_err   = out_err_r;
    assign busy      = busy_r;

    // Selects the held digit addressed by idx_r and converts it.
    always_comb begin
        cur_digit_s = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            cur_digit_s = cur_digit_s | (data_r[4*i +: 4] & {4{idx_r == IDX_W'(i)}});
        end
        conv_s = conv_digit(cur_digit_s, mode_r);
    end

    // Next-state logic for the IDLE -> CONV -> DONE sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_nxt_s = CONV;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CONV: begin
                if (idx_r == LAST_IDX) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = CONV;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register. out_valid and busy are registered from the next state,
    // so they line up exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            out_valid_r <= (state_nxt_s == DONE);
            busy_r      <= (state_nxt_s != IDLE);
        end
    end

    // Datapath. The word and mode are captured only at acceptance. Each CONV
    // cycle writes one result digit. idx stops at the last digit instead of
    // wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r      <= '0;
            data_r     <= '0;
            mode_r     <= 1'b0;
            out_data_r <= '0;
            out_err_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        data_r     <= in_data;
                        mode_r     <= in_mode;
                        idx_r      <= '0;
                        out_data_r <= '0;
                        out_err_r  <= '0;
                    end
                end
                CONV: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (idx_r == IDX_W'(i)) begin
                            out_data_r[4*i +: 4] <= conv_s[3:0];
                            out_err_r[i]         <= conv_s[4];
                        end
                    end
                    if (idx_r != LAST_IDX) begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                DONE: begin
                    idx_r <= idx_r;
                end
                default: begin
                    idx_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_xs3_seq_converter.sv
module tb_bcd_xs3_seq_converter;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  err;
        int          acc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    // DIGITS = 4 instance (a_*)
    logic        a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_busy;
    logic [15:0] a_in_data, a_out_data;
    logic [3:0]  a_out_err;
    // DIGITS = 1 instance (b_*)
    logic        b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_busy;
    logic [3:0]  b_in_data, b_out_data;
    logic [0:0]  b_out_err;

    exp_t q4[$];
    exp_t q1[$];

    bcd_xs3_seq_converter #(.DIGITS(4)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_err(a_out_err),
        .busy(a_busy)
    );

    bcd_xs3_seq_converter #(.DIGITS(1)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_err(b_out_err),
        .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: treat the word as DIGITS base-16 digits and apply the
    // code tables arithmetically.
    function automatic exp_t model(input logic [15:0] d, input logic m, input int n);
        exp_t e;
        int   v;
        int   r;
        e.data = 16'h0000;
        e.err  = 4'h0;
        e.acc  = 0;
        for (int i = 0; i < n; i++) begin
            v = (int'(d) / (1 << (4 * i))) % 16;
            if (m == 1'b0 && v <= 9)               r = v + 3;
            else if (m == 1'b1 && v >= 3 && v <= 12) r = v - 3;
            else begin
                r = 15;
                e.err[i] = 1'b1;
            end
            e.data = e.data | 16'(r << (4 * i));
        end
        return e;
    endfunction

    // Scoreboard monitor for the 4-digit instance.
    bit a_prev;
    exp_t a_e;
    always @(negedge clk) begin
        if (a_out_valid && !a_prev) begin
            chk("a_valid_expected", 32'(q4.size() > 0), 32'd1);
            if (q4.size() > 0) chk("a_latency", 32'(cyc - q4[0].acc), 32'd4);
        end
        if (a_out_valid && a_out_ready && q4.size() > 0) begin
            a_e = q4.pop_front();
            chk("a_out_data", 32'(a_out_data), 32'(a_e.data));
            chk("a_out_err", 32'(a_out_err), 32'(a_e.err));
        end
        a_prev = a_out_valid;
    end

    // Scoreboard monitor for the 1-digit instance.
    bit b_prev;
    exp_t b_e;
    always @(negedge clk) begin
        if (b_out_valid && !b_prev) begin
            chk("b_valid_expected", 32'(q1.size() > 0), 32'd1);
            if (q1.size() > 0) chk("b_latency", 32'(cyc - q1[0].acc), 32'd1);
        end
        if (b_out_valid && b_out_ready && q1.size() > 0) begin
            b_e = q1.pop_front();
            chk("b_out_data", 32'(b_out_data), 32'(b_e.data));
            chk("b_out_err", 32'(b_out_err), 32'(b_e.err));
        end
        b_prev = b_out_valid;
    end

    // Issues one word to instance sel (0 = 4 digits, 1 = 1 digit) and pushes
    // its expected result. acc is the index of the accepting edge.
    task automatic send(input bit sel, input logic [15:0] d, input logic m, output int acc);
        int   k;
        exp_t e;
        k = 0;
        while (!(sel ? b_in_ready : a_in_ready) && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("send_ready_wait", 32'(sel ? b_in_ready : a_in_ready), 32'd1);
        if (sel) begin
            b_in_valid = 1'b1; b_in_data = d[3:0]; b_in_mode = m;
        end else begin
            a_in_valid = 1'b1; a_in_data = d; a_in_mode = m;
        end
        acc   = cyc + 1;
        e     = model(d, m, sel ? 1 : 4);
        e.acc = acc;
        if (sel) q1.push_back(e);
        else     q4.push_back(e);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        int k;
        k = 0;
        while ((q4.size() > 0 || q1.size() > 0) && k < 300) begin
            if (rnd) begin
                a_out_ready = 1'($urandom_range(0, 1));
                b_out_ready = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            k++;
        end
        chk("drain_done", 32'(q4.size() + q1.size()), 32'd0);
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_valid(input bit sel);
        int k;
        k = 0;
        while (!(sel ? b_out_valid : a_out_valid) && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("wait_out_valid", 32'(sel ? b_out_valid : a_out_valid), 32'd1);
    endtask

    int   acc0, acc1, acc2;
    exp_t bp;

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_data = 16'h0000; a_in_mode = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = 4'h0;     b_in_mode = 1'b0; b_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_data", 32'(a_out_data), 32'd0);
        chk("rst_out_err", 32'(a_out_err), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_in_ready", 32'(a_in_ready), 32'd1);
        chk("rst_b_in_ready", 32'(b_in_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed words, 4 digits
        send(1'b0, 16'h1234, 1'b0, acc0); drain(1'b0);
        send(1'b0, 16'h9A05, 1'b0, acc0); drain(1'b0);
        send(1'b0, 16'h4567, 1'b1, acc0); drain(1'b0);
        send(1'b0, 16'h3C20, 1'b1, acc0); drain(1'b0);

        // Backpressure in DONE
        a_out_ready = 1'b0;
        send(1'b0, 16'h0789, 1'b0, acc0);
        bp = model(16'h0789, 1'b0, 4);
        wait_valid(1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 32'(a_out_valid), 32'd1);
            chk("bp_out_data", 32'(a_out_data), 32'(bp.data));
            chk("bp_out_err", 32'(a_out_err), 32'(bp.err));
            chk("bp_in_ready", 32'(a_in_ready), 32'd0);
            @(posedge clk); #1;
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 32'(a_out_valid), 32'd0);
        chk("bp_release_ready", 32'(a_in_ready), 32'd1);

        // Back-to-back words: period DIGITS+2
        send(1'b0, 16'h0918, 1'b0, acc0);
        send(1'b0, 16'h5BC3, 1'b1, acc1);
        send(1'b0, 16'hF00D, 1'b0, acc2);
        chk("period_1", 32'(acc1 - acc0), 32'd6);
        chk("period_2", 32'(acc2 - acc1), 32'd6);
        drain(1'b0);

        // Input changes during CONV are ignored
        send(1'b0, 16'h2468, 1'b1, acc0);
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 16'($urandom);
            a_in_mode  = ~a_in_mode;
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        drain(1'b0);

        // Reset during the 2nd CONV cycle, with in_valid also high
        send(1'b0, 16'h5678, 1'b0, acc0);
        @(posedge clk); #1;
        rst = 1'b1;
        a_in_valid = 1'b1; a_in_data = 16'h1111; a_in_mode = 1'b0;
        @(posedge clk); #1;
        q4.delete();
        chk("abort_out_valid", 32'(a_out_valid), 32'd0);
        chk("abort_out_data", 32'(a_out_data), 32'd0);
        chk("abort_out_err", 32'(a_out_err), 32'd0);
        chk("abort_busy", 32'(a_busy), 32'd0);
        chk("abort_in_ready", 32'(a_in_ready), 32'd1);
        @(posedge clk); #1;
        chk("rst_beats_valid", 32'(a_busy), 32'd0);
        rst = 1'b0;
        a_in_valid = 1'b0;
        send(1'b0, 16'h0000, 1'b0, acc0);
        drain(1'b0);

        // One-digit instance
        send(1'b1, 16'h0001, 1'b0, acc0); drain(1'b0);
        send(1'b1, 16'h0009, 1'b0, acc0); drain(1'b0);
        send(1'b1, 16'h000A, 1'b0, acc0); drain(1'b0);
        send(1'b1, 16'h0004, 1'b1, acc0); drain(1'b0);
        send(1'b1, 16'h0002, 1'b1, acc0); drain(1'b0);
        b_out_ready = 1'b0;
        send(1'b1, 16'h0005, 1'b0, acc0);
        wait_valid(1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        q1.delete();
        chk("b_abort_out_valid", 32'(b_out_valid), 32'd0);
        chk("b_abort_out_data", 32'(b_out_data), 32'd0);
        chk("b_abort_out_err", 32'(b_out_err), 32'd0);
        chk("b_abort_busy", 32'(b_busy), 32'd0);
        chk("b_abort_in_ready", 32'(b_in_ready), 32'd1);
        rst = 1'b0;
        b_out_ready = 1'b1;
        send(1'b1, 16'h0000, 1'b0, acc0);
        drain(1'b0);

        // Randomized words with random backpressure
        for (int n = 0; n < 40; n++) begin
            send(1'b0, 16'($urandom), 1'($urandom_range(0, 1)), acc0);
            drain(1'b1);
        end
        for (int n = 0; n < 20; n++) begin
            send(1'b1, 16'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), acc0);
            drain(1'b1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("final_a_idle", 32'(a_busy), 32'd0);
        chk("final_b_idle", 32'(b_busy), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
